// File: rtl/npc_bus_pkg.sv
// Shared types for the core's memory bus arbiter: FSM states, bus owner
// identifiers and the registered memory request.
package npc_bus_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } arb_owner_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } mem_req_t;

  // Instruction fetches are always plain reads: no write enable, no byte lanes.
  function automatic mem_req_t ifu_fetch_req(input logic [31:0] addr);
    mem_req_t r;
    r.addr  = addr;
    r.wen   = 1'b0;
    r.wdata = '0;
    r.wmask = '0;
    return r;
  endfunction

  // Round-robin partner of the master that was granted last.
  function automatic arb_owner_t other_owner(input arb_owner_t o);
    return (o == OWN_IFU) ? OWN_LSU : OWN_IFU;
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational two-way picker between the IFU and LSU request lines.
// With RR_EN set, a tie goes to the master that was not granted last;
// otherwise the LSU always wins a tie.
module arb_pick
  import npc_bus_pkg::*;
#(
  parameter int unsigned RR_EN = 1
) (
  input  logic       ifu_valid,
  input  logic       lsu_valid,
  input  arb_owner_t rr_last,
  output arb_owner_t winner
);

  // Select the winner; defaults to IFU when nothing else applies.
  always_comb begin
    winner = OWN_IFU;
    if (ifu_valid && lsu_valid) begin
      if (RR_EN != 0) begin
        winner = other_owner(rr_last);
      end else begin
        winner = OWN_LSU;
      end
    end else if (lsu_valid) begin
      winner = OWN_LSU;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single memory port between the IFU (read-only) and the LSU.
// One request is in flight at a time: the winner is registered, forwarded
// to memory, and the grant is held until its response handshake completes
// or the slave times out, in which case an error response is forced.
module mem_arbiter
  import npc_bus_pkg::*;
#(
  parameter int unsigned RR_EN   = 1,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 8
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_addr,
  output logic        ifu_resp_valid,
  input  logic        ifu_resp_ready,
  output logic [31:0] ifu_rdata,
  output logic        ifu_err,

  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [31:0] lsu_addr,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wmask,
  output logic        lsu_resp_valid,
  input  logic        lsu_resp_ready,
  output logic [31:0] lsu_rdata,
  output logic        lsu_err,

  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_resp_valid,
  output logic        mem_resp_ready,
  input  logic [31:0] mem_rdata,
  input  logic        mem_err
);

  // The counter is cleared on entry to S_RESP and advances once per silent
  // cycle, so it equals TIMEOUT-1 on the TIMEOUT-th silent S_RESP cycle;
  // that is the cycle the error response is forced.
  localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);

  arb_state_t      state;
  arb_owner_t      owner;
  arb_owner_t      rr_last;
  mem_req_t        req_q;
  mem_req_t        req_next;
  logic [TO_W-1:0] to_cnt;

  arb_owner_t      winner;
  logic            any_req;
  logic            idle_ok;
  logic            in_req;
  logic            in_resp;
  logic            timed_out;
  logic            owner_ready;
  logic            resp_valid;
  logic [31:0]     resp_data;
  logic            resp_err;

  arb_pick #(
    .RR_EN (RR_EN)
  ) u_pick (
    .ifu_valid (ifu_req_valid),
    .lsu_valid (lsu_req_valid),
    .rr_last   (rr_last),
    .winner    (winner)
  );

  // Phase qualifiers; everything handshake-related is suppressed during reset.
  always_comb begin
    any_req     = ifu_req_valid | lsu_req_valid;
    idle_ok     = (state == S_IDLE) && !rst;
    in_req      = (state == S_REQ) && !rst;
    in_resp     = (state == S_RESP) && !rst;
    timed_out   = (TIMEOUT != 0) && (state == S_RESP) && (to_cnt == TO_LAST);
    owner_ready = (owner == OWN_LSU) ? lsu_resp_ready : ifu_resp_ready;
  end

  // Request register contents for the master that wins this cycle.
  always_comb begin
    req_next = ifu_fetch_req(ifu_addr);
    if (winner == OWN_LSU) begin
      req_next.addr  = lsu_addr;
      req_next.wen   = lsu_wen;
      req_next.wdata = lsu_wdata;
      req_next.wmask = lsu_wmask;
    end
  end

  // Master request acceptance: only the winner sees ready, only in S_IDLE.
  always_comb begin
    ifu_req_ready = idle_ok && ifu_req_valid && (winner == OWN_IFU);
    lsu_req_ready = idle_ok && lsu_req_valid && (winner == OWN_LSU);
  end

  // Forward the registered request; it is stable for as long as S_REQ lasts.
  always_comb begin
    mem_req_valid = in_req;
    mem_addr      = req_q.addr;
    mem_wen       = req_q.wen;
    mem_wdata     = req_q.wdata;
    mem_wmask     = req_q.wmask;
  end

  // Response steering: memory passes straight through to the owner unless
  // the timeout has expired, which substitutes a zero-data error and stops
  // accepting from memory so a late response is dropped.
  always_comb begin
    resp_valid     = in_resp && (timed_out || mem_resp_valid);
    resp_data      = timed_out ? '0 : mem_rdata;
    resp_err       = timed_out | mem_err;
    mem_resp_ready = in_resp && !timed_out && owner_ready;

    ifu_resp_valid = resp_valid && (owner == OWN_IFU);
    lsu_resp_valid = resp_valid && (owner == OWN_LSU);
    ifu_rdata      = ifu_resp_valid ? resp_data : '0;
    lsu_rdata      = lsu_resp_valid ? resp_data : '0;
    ifu_err        = ifu_resp_valid & resp_err;
    lsu_err        = lsu_resp_valid & resp_err;
  end

  // Arbiter FSM, request register and timeout counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      owner   <= OWN_IFU;
      rr_last <= OWN_IFU;
      req_q   <= '0;
      to_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            req_q   <= req_next;
            owner   <= winner;
            rr_last <= winner;
            state   <= S_REQ;
          end
        end
        S_REQ: begin
          if (mem_req_ready) begin
            to_cnt <= '0;
            state  <= S_RESP;
          end
        end
        S_RESP: begin
          if (resp_valid && owner_ready) begin
            state <= S_IDLE;
          end else if (!mem_resp_valid && !timed_out) begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
